// File: rtl/ia_color_centroid_pkg.sv
// Shared types and widths for the colour-centroid block and its divider.
package ia_color_centroid_pkg;

  localparam int IMG_W     = 128;
  localparam int IMG_H     = 128;
  localparam int PLANE_OFS = 16384;
  localparam int ADDR_W    = 16;
  localparam int CNT_W     = 15;
  localparam int SUM_W     = 21;
  localparam int COORD_W   = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DIVX,
    S_DIVY,
    S_DONE
  } state_e;

  // Word address of pixel index pix in colour plane (0=R, 1=G, 2=B).
  function automatic logic [ADDR_W-1:0] plane_addr(input logic [1:0]        plane,
                                                   input logic [ADDR_W-1:0] pix,
                                                   input int                ofs);
    logic [ADDR_W-1:0] base;
    case (plane)
      2'd1:    base = ADDR_W'(ofs);
      2'd2:    base = ADDR_W'(2 * ofs);
      default: base = '0;
    endcase
    return base + pix;
  endfunction

endpackage

// File: rtl/ia_color_centroid_divider.sv
// Restoring serial divider, 21-bit dividend by 15-bit divisor; the quotient
// and a done pulse appear 22 cycles after the start cycle.
module serial_divider_u21
  import ia_color_centroid_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             done_o,
  output logic [SUM_W-1:0] quotient_o
);

  localparam int CW = $clog2(SUM_W);

  logic [SUM_W-1:0] quo_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W:0]   shifted_d;
  logic [CNT_W+1:0] diff_d;
  logic [CNT_W-1:0] rem_d;
  logic             qbit_d;
  logic             rem_hi_unused;

  // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    shifted_d = {rem_q, quo_q[SUM_W-1]};
    diff_d    = {1'b0, shifted_d} - {2'b00, dvs_q};
    qbit_d    = ~diff_d[CNT_W+1];
    rem_d     = qbit_d ? diff_d[CNT_W-1:0] : shifted_d[CNT_W-1:0];
  end

  assign rem_hi_unused = diff_d[CNT_W] | shifted_d[CNT_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        quo_q  <= dividend_i;
        rem_q  <= '0;
        dvs_q  <= divisor_i;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        quo_q <= {quo_q[SUM_W-2:0], qbit_d};
        rem_q <= rem_d;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(SUM_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/ia_color_centroid.sv
// Scans the R/G/B capture planes, classifies each pixel against a reference
// colour with tolerance, and reports match count, bounding box and centroid.
module ia_color_centroid #(
  parameter int IMG_W     = ia_color_centroid_pkg::IMG_W,
  parameter int IMG_H     = ia_color_centroid_pkg::IMG_H,
  parameter int DATA_W    = 10,
  parameter int PLANE_OFS = ia_color_centroid_pkg::PLANE_OFS,
  parameter int MIN_COUNT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_ref_R,
  input  logic [DATA_W-1:0] i_ref_G,
  input  logic [DATA_W-1:0] i_ref_B,
  input  logic [DATA_W-1:0] i_tol,
  output logic              o_rd_en,
  output logic [15:0]       o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_found,
  output logic [14:0]       o_count,
  output logic [6:0]        o_cx,
  output logic [6:0]        o_cy,
  output logic [6:0]        o_xmin,
  output logic [6:0]        o_xmax,
  output logic [6:0]        o_ymin,
  output logic [6:0]        o_ymax
);

  import ia_color_centroid_pkg::*;

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int PIX_W = $clog2(NPIX);
  localparam int XW    = $clog2(IMG_W);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);

  // Issue side
  state_e              state_q;
  logic [PIX_W-1:0]    pix_q;
  logic [1:0]          ph_q;
  logic                drain_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [DATA_W-1:0]   ref_r_q, ref_g_q, ref_b_q, tol_q;

  // Return side and accumulators
  logic                ret_vld_q;
  logic [1:0]          ret_ph_q;
  logic [PIX_W-1:0]    ret_pix_q;
  logic [DATA_W-1:0]   r_q, g_q;
  logic [CNT_W-1:0]    count_q;
  logic [SUM_W-1:0]    sum_x_q, sum_y_q;
  logic [COORD_W-1:0]  xmin_q, xmax_q, ymin_q, ymax_q;

  // Result registers
  logic [COORD_W-1:0]  cx_tmp_q;
  logic                done_q, found_q;
  logic [CNT_W-1:0]    res_count_q;
  logic [COORD_W-1:0]  res_cx_q, res_cy_q;
  logic [COORD_W-1:0]  res_xmin_q, res_xmax_q, res_ymin_q, res_ymax_q;

  logic [1:0]          ph_d;
  logic [PIX_W-1:0]    pix_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [COORD_W-1:0]  x_d, y_d;
  logic                match_d;
  logic                start_acc_d;
  logic                found_d;
  logic                div_start_d;
  logic [SUM_W-1:0]    div_dvd_d;
  logic                div_done;
  logic [SUM_W-1:0]    div_quo;
  logic                div_hi_unused;

  function automatic logic [DATA_W:0] abs_diff(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DATA_W] ? -d : d;
  endfunction

  always_comb begin
    ph_d        = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
    pix_d       = (ph_q == 2'd2) ? pix_q + PIX_W'(1) : pix_q;
    addr_d      = plane_addr(ph_d, ADDR_W'(pix_d), PLANE_OFS);
    x_d         = COORD_W'(ret_pix_q[XW-1:0]);
    y_d         = COORD_W'(ret_pix_q[PIX_W-1:XW]);
    start_acc_d = (state_q == S_IDLE) && i_start;
    found_d     = (count_q >= CNT_W'(MIN_COUNT));
    // B arrives on the bus in the same cycle R and G are already registered.
    match_d     = ret_vld_q && (ret_ph_q == 2'd2)
                  && (abs_diff(r_q, ref_r_q)       <= {1'b0, tol_q})
                  && (abs_diff(g_q, ref_g_q)       <= {1'b0, tol_q})
                  && (abs_diff(i_rd_data, ref_b_q) <= {1'b0, tol_q});
    // The second division is launched in the same cycle the first one reports done.
    div_start_d = ((state_q == S_DRAIN) && drain_q && found_d)
                  || ((state_q == S_DIVX) && div_done);
    div_dvd_d   = (state_q == S_DRAIN) ? sum_x_q : sum_y_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      pix_q       <= '0;
      ph_q        <= 2'd0;
      drain_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      ref_r_q     <= '0;
      ref_g_q     <= '0;
      ref_b_q     <= '0;
      tol_q       <= '0;
      cx_tmp_q    <= '0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      res_count_q <= '0;
      res_cx_q    <= '0;
      res_cy_q    <= '0;
      res_xmin_q  <= '0;
      res_xmax_q  <= '0;
      res_ymin_q  <= '0;
      res_ymax_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q   <= S_SCAN;
            pix_q     <= '0;
            ph_q      <= 2'd0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            ref_r_q   <= i_ref_R;
            ref_g_q   <= i_ref_G;
            ref_b_q   <= i_ref_B;
            tol_q     <= i_tol;
          end
        end
        S_SCAN: begin
          if ((ph_q == 2'd2) && (pix_q == PIX_LAST)) begin
            state_q   <= S_DRAIN;
            drain_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
          end else begin
            pix_q     <= pix_d;
            ph_q      <= ph_d;
            rd_addr_q <= addr_d;
          end
        end
        S_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            if (found_d) begin
              state_q <= S_DIVX;
            end else begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              found_q     <= 1'b0;
              res_count_q <= count_q;
              res_cx_q    <= '0;
              res_cy_q    <= '0;
              res_xmin_q  <= '0;
              res_xmax_q  <= '0;
              res_ymin_q  <= '0;
              res_ymax_q  <= '0;
            end
          end
        end
        S_DIVX: begin
          if (div_done) begin
            cx_tmp_q <= div_quo[COORD_W-1:0];
            state_q  <= S_DIVY;
          end
        end
        S_DIVY: begin
          if (div_done) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            found_q     <= 1'b1;
            res_count_q <= count_q;
            res_cx_q    <= cx_tmp_q;
            res_cy_q    <= div_quo[COORD_W-1:0];
            res_xmin_q  <= xmin_q;
            res_xmax_q  <= xmax_q;
            res_ymin_q  <= ymin_q;
            res_ymax_q  <= ymax_q;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ret_vld_q <= 1'b0;
      ret_ph_q  <= 2'd0;
      ret_pix_q <= '0;
      r_q       <= '0;
      g_q       <= '0;
      count_q   <= '0;
      sum_x_q   <= '0;
      sum_y_q   <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymin_q    <= '0;
      ymax_q    <= '0;
    end else begin
      ret_vld_q <= rd_en_q;
      ret_ph_q  <= ph_q;
      ret_pix_q <= pix_q;
      if (ret_vld_q && (ret_ph_q == 2'd0)) r_q <= i_rd_data;
      if (ret_vld_q && (ret_ph_q == 2'd1)) g_q <= i_rd_data;
      if (start_acc_d) begin
        count_q <= '0;
        sum_x_q <= '0;
        sum_y_q <= '0;
        xmin_q  <= '0;
        xmax_q  <= '0;
        ymin_q  <= '0;
        ymax_q  <= '0;
      end else if (match_d) begin
        count_q <= count_q + CNT_W'(1);
        sum_x_q <= sum_x_q + SUM_W'(x_d);
        sum_y_q <= sum_y_q + SUM_W'(y_d);
        // A zero count means this is the first match: it seeds all four bounds.
        if (count_q == '0) begin
          xmin_q <= x_d;
          xmax_q <= x_d;
          ymin_q <= y_d;
          ymax_q <= y_d;
        end else begin
          if (x_d < xmin_q) xmin_q <= x_d;
          if (x_d > xmax_q) xmax_q <= x_d;
          if (y_d < ymin_q) ymin_q <= y_d;
          if (y_d > ymax_q) ymax_q <= y_d;
        end
      end
    end
  end

  serial_divider_u21 u_div (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .start_i    (div_start_d),
    .dividend_i (div_dvd_d),
    .divisor_i  (count_q),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  // The centroid never exceeds the largest coordinate, so only the low bits matter.
  assign div_hi_unused = |div_quo[SUM_W-1:COORD_W];

  assign o_rd_en   = rd_en_q;
  assign o_rd_addr = rd_addr_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = done_q;
  assign o_found   = found_q;
  assign o_count   = res_count_q;
  assign o_cx      = res_cx_q;
  assign o_cy      = res_cy_q;
  assign o_xmin    = res_xmin_q;
  assign o_xmax    = res_xmax_q;
  assign o_ymin    = res_ymin_q;
  assign o_ymax    = res_ymax_q;

endmodule

// File: tb/tb_ia_color_centroid.sv
// Bench: a full 128x128 instance for the all-match timing case, and a 32x64
// instance for table-driven scenes, restart, reset and read-protocol checks.
module tb_ia_color_centroid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit full_done = 1'b0;

  // Small instance
  logic        rst_n, start_s;
  logic [9:0]  ref_r, ref_g, ref_b, tol;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [9:0]  rd_data;
  logic        busy, done, found;
  logic [14:0] count;
  logic [6:0]  cx, cy, xmin, xmax, ymin, ymax;
  int          scene = 0;

  // Full-size instance
  logic        rst_nf, start_f;
  logic [9:0]  zero10 = 10'd0;
  logic        rd_en_f;
  logic [15:0] rd_addr_f;
  logic [9:0]  rd_data_f;
  logic        busy_f, done_f, found_f;
  logic [14:0] count_f;
  logic [6:0]  cx_f, cy_f, xmin_f, xmax_f, ymin_f, ymax_f;

  ia_color_centroid #(.IMG_W(32), .IMG_H(64), .PLANE_OFS(2048)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s),
    .i_ref_R(ref_r), .i_ref_G(ref_g), .i_ref_B(ref_b), .i_tol(tol),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_busy(busy), .o_done(done), .o_found(found), .o_count(count),
    .o_cx(cx), .o_cy(cy), .o_xmin(xmin), .o_xmax(xmax), .o_ymin(ymin), .o_ymax(ymax)
  );

  ia_color_centroid dut_full (
    .i_clk(clk), .i_rst_n(rst_nf), .i_start(start_f),
    .i_ref_R(zero10), .i_ref_G(zero10), .i_ref_B(zero10), .i_tol(zero10),
    .o_rd_en(rd_en_f), .o_rd_addr(rd_addr_f), .i_rd_data(rd_data_f),
    .o_busy(busy_f), .o_done(done_f), .o_found(found_f), .o_count(count_f),
    .o_cx(cx_f), .o_cy(cy_f), .o_xmin(xmin_f), .o_xmax(xmax_f), .o_ymin(ymin_f), .o_ymax(ymax_f)
  );

  // Scene model for the 32x64 image, planes 2048 words apart.
  function automatic logic [9:0] pix_val(input int sc, input int addr);
    int plane, p, x, y;
    logic [9:0] v;
    plane = addr / 2048;
    p = addr % 2048;
    x = p % 32;
    y = p / 32;
    v = 10'd0;
    case (sc)
      1: if (x >= 20 && x <= 29 && y >= 40 && y <= 49)
           v = (plane == 0) ? 10'd500 : (plane == 1) ? 10'd200 : 10'd100;
      2, 3: if (y == 7 && x >= 2 && x < ((sc == 2) ? 17 : 18)) v = 10'd300;
      4: case (plane)
           0:       v = (p % 2 == 1) ? 10'd1023 : 10'd0;
           1:       v = (p % 2 == 1) ? 10'd0 : 10'd1023;
           default: v = (x < 16) ? 10'd1023 : 10'd0;
         endcase
      default: v = 10'd0;
    endcase
    return v;
  endfunction

  // One-cycle read latency; junk when not enabled.
  always @(posedge clk) begin
    rd_data   <= rd_en ? pix_val(scene, int'(rd_addr)) : 10'h2AA;
    rd_data_f <= rd_en_f ? 10'd0 : 10'h2AA;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int scene;
    int rr, rg, rb, tol;
    int found, count, cx, cy, xmin, xmax, ymin, ymax, done_cyc;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];
  int exp_full_addr[6] = '{0, 16384, 32768, 1, 16385, 32769};

  task automatic run_vec(input int i);
    int c0, waited;
    bit seen;
    vec_t v;
    v = vecs[i];
    scene = v.scene;
    ref_r = 10'(v.rr); ref_g = 10'(v.rg); ref_b = 10'(v.rb); tol = 10'(v.tol);
    @(negedge clk);
    start_s = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start_s = 1'b0;
    // References are latched at start; scrambling them must not matter.
    ref_r = 10'd0; ref_g = 10'd0; ref_b = 10'd0; tol = 10'd0;
    seen = 1'b0;
    for (waited = 0; waited < 8000 && !seen; waited++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk($sformatf("v%0d_done_seen", i), 32'(seen), 32'd1);
    chk($sformatf("v%0d_done_cycle", i), cyc - c0, v.done_cyc);
    chk($sformatf("v%0d_found", i), 32'(found), v.found);
    chk($sformatf("v%0d_count", i), 32'(count), v.count);
    chk($sformatf("v%0d_cx", i), 32'(cx), v.cx);
    chk($sformatf("v%0d_cy", i), 32'(cy), v.cy);
    chk($sformatf("v%0d_xmin", i), 32'(xmin), v.xmin);
    chk($sformatf("v%0d_xmax", i), 32'(xmax), v.xmax);
    chk($sformatf("v%0d_ymin", i), 32'(ymin), v.ymin);
    chk($sformatf("v%0d_ymax", i), 32'(ymax), v.ymax);
    $display("[TB] vec %0d scene %0d: done@%0d found=%0d count=%0d c=(%0d,%0d) box x %0d..%0d y %0d..%0d",
             i, v.scene, cyc - c0, found, count, cx, cy, xmin, xmax, ymin, ymax);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
    chk($sformatf("v%0d_hold_count", i), 32'(count), v.count);
  endtask

  task automatic restart_and_reset();
    int c0, bad, first_bad_k, exp_addr;
    scene = 1;
    ref_r = 10'd505; ref_g = 10'd195; ref_b = 10'd100; tol = 10'd5;
    @(negedge clk);
    start_s = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start_s = 1'b0;
    bad = 0;
    first_bad_k = -1;
    for (int k = 1; k <= 600; k++) begin
      exp_addr = ((k - 1) % 3) * 2048 + (k - 1) / 3;
      if (rd_en !== 1'b1 || int'(rd_addr) != exp_addr) begin
        bad++;
        if (first_bad_k < 0) first_bad_k = k;
      end
      if (k == 300) begin
        start_s = 1'b1;
        ref_r = 10'd0; ref_g = 10'd0; ref_b = 10'd0; tol = 10'd0;
      end
      if (k == 301) start_s = 1'b0;
      @(negedge clk);
    end
    chk("restart_addr_seq_errors", bad, 0);
    chk("restart_still_busy", 32'(busy), 32'd1);
    $display("[TB] restart mid-scan: %0d address errors (first at cycle %0d)", bad, first_bad_k);
    repeat (2000 - 601) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rd_en", 32'(rd_en), 32'd0);
    chk("rst_mid_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_found", 32'(found), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_cx", 32'(cx), 32'd0);
    chk("rst_mid_cy", 32'(cy), 32'd0);
    chk("rst_mid_box", {xmin, xmax, ymin, ymax}, 32'd0);
    $display("[TB] reset at cycle %0d of scan: rd_en=%0d busy=%0d count=%0d", cyc - c0, rd_en, busy, count);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : main
    int waited;
    vecs[0] = '{1, 505, 195, 100, 5,  1, 100,  24, 44, 20, 29, 40, 49, 6191};
    vecs[1] = '{1, 505, 195, 100, 4,  0, 0,    0,  0,  0,  0,  0,  0,  6147};
    vecs[2] = '{1, 505, 195, 106, 5,  0, 0,    0,  0,  0,  0,  0,  0,  6147};
    vecs[3] = '{2, 300, 300, 300, 0,  0, 15,   0,  0,  0,  0,  0,  0,  6147};
    vecs[4] = '{3, 300, 300, 300, 0,  1, 16,   9,  7,  2,  17, 7,  7,  6191};
    vecs[5] = '{4, 1023, 1023, 1023, 1023, 1, 2048, 15, 31, 0, 31, 0, 63, 6191};

    rst_n = 1'b0;
    start_s = 1'b0;
    ref_r = 10'd0; ref_g = 10'd0; ref_b = 10'd0; tol = 10'd0;
    repeat (3) @(negedge clk);
    chk("reset_rd_en", 32'(rd_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_coords", {cx, cy, xmin, xmax}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(i);
    restart_and_reset();
    run_vec(0);

    waited = 0;
    while (!full_done && waited < 60000) begin
      @(negedge clk);
      waited++;
    end
    chk("full_run_finished", 32'(full_done), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : full_run
    int c0, waited;
    bit seen;
    rst_nf = 1'b0;
    start_f = 1'b0;
    repeat (3) @(negedge clk);
    chk("full_reset_count", 32'(count_f), 32'd0);
    chk("full_reset_busy", 32'(busy_f), 32'd0);
    rst_nf = 1'b1;
    @(negedge clk);
    start_f = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start_f = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("full_addr%0d", k), 32'(rd_addr_f), exp_full_addr[k]);
      chk($sformatf("full_rd_en%0d", k), 32'(rd_en_f), 32'd1);
      @(negedge clk);
    end
    seen = 1'b0;
    for (waited = 0; waited < 60000 && !seen; waited++) begin
      if (done_f) seen = 1'b1;
      else @(negedge clk);
    end
    chk("full_done_seen", 32'(seen), 32'd1);
    chk("full_done_cycle", cyc - c0, 49199);
    chk("full_found", 32'(found_f), 32'd1);
    chk("full_count", 32'(count_f), 32'd16384);
    chk("full_cx", 32'(cx_f), 32'd63);
    chk("full_cy", 32'(cy_f), 32'd63);
    chk("full_xmin", 32'(xmin_f), 32'd0);
    chk("full_xmax", 32'(xmax_f), 32'd127);
    chk("full_ymin", 32'(ymin_f), 32'd0);
    chk("full_ymax", 32'(ymax_f), 32'd127);
    @(negedge clk);
    chk("full_rd_en_after", 32'(rd_en_f), 32'd0);
    $display("[TB] full 128x128 all-zero: done@%0d found=%0d count=%0d c=(%0d,%0d) box x %0d..%0d y %0d..%0d",
             cyc - c0 - 1, found_f, count_f, cx_f, cy_f, xmin_f, xmax_f, ymin_f, ymax_f);
    full_done = 1'b1;
  end

endmodule

// File: doc/ia_color_centroid.md
# ia_color_centroid

Downstream consumer of the 128x128 RGB capture buffer produced by the window-capture/downsampling stage. On each start pulse it scans the three 10-bit colour planes through a one-cycle-latency read port, classifies each pixel against a reference colour with a per-channel tolerance, and accumulates the matching pixels. It then reports the match count, the bounding box and the floor-rounded centroid, which the object-tracking overlay logic consumes.

## Interface
- IMG_W, 128: image width in pixels (power of two).
- IMG_H, 128: image height in pixels.
- DATA_W, 10: colour sample width.
- PLANE_OFS, 16384: word offset between the R, G and B planes (R at 0).
- MIN_COUNT, 16: minimum match count for a valid object (must be >= 1).
- i_clk, in, 1: clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_start, in, 1: start pulse, normally driven by the capture stage's finish; sampled only in S_IDLE.
- i_ref_R / i_ref_G / i_ref_B, in, 10 each: reference colour, latched on the accepted start.
- i_tol, in, 10: per-channel tolerance, latched on the accepted start.
- o_rd_en, out, 1: read strobe.
- o_rd_addr, out, 16: read word address.
- i_rd_data, in, 10: read data, valid exactly one cycle after o_rd_en.
- o_busy, out, 1: high in every state except S_IDLE.
- o_done, out, 1: one-cycle pulse when the results update.
- o_found, out, 1: count >= MIN_COUNT.
- o_count, out, 15: number of matching pixels (0..16384).
- o_cx / o_cy, out, 7 each: centroid.
- o_xmin / o_xmax / o_ymin / o_ymax, out, 7 each: bounding box.

## Operation
- States: S_IDLE, S_SCAN, S_DRAIN, S_DIVX, S_DIVY, S_DONE.
- S_IDLE -> S_SCAN on i_start. On entry the block latches the reference colour and tolerance, and clears the accumulators.
- S_SCAN scans pixel p = 0..16383 in raster order (x = p[6:0], y = p[13:7]).
  - Three consecutive reads per pixel: addresses p, PLANE_OFS+p, 2*PLANE_OFS+p.
  - o_rd_en is high every cycle of S_SCAN.
- The R and G samples are held in registers. When the B sample arrives, the pixel is classified.
- Match rule: |R-refR| <= tol AND |G-refG| <= tol AND |B-refB| <= tol.
  - Differences are computed at 11 bits signed; the comparison is unsigned on the magnitude.
- On a match:
  - count += 1
  - sum_x += x (21 bits)
  - sum_y += y (21 bits)
  - min/max of x and y update. The first match initialises all four bounds.
- S_DRAIN lasts 2 cycles and retires the final pixel.
  - If count < MIN_COUNT, go straight to S_DONE with found = 0, and cx, cy and all bounds = 0.
  - Otherwise go to S_DIVX.
- S_DIVX computes cx = floor(sum_x / count); S_DIVY computes cy = floor(sum_y / count). Both use the shared serial divider.
- S_DONE lasts one cycle: it registers all outputs, pulses o_done, and returns to S_IDLE.
- Results hold until the next o_done.
- i_start is ignored while o_busy.
- Reset at any point, including mid-scan, returns the block to S_IDLE and clears every output and accumulator.

## Timing
- Reset values: every output is 0.
- Cycle 0: i_start sampled high in S_IDLE.
- S_SCAN occupies cycles 1..49152. Pixel p issues R at cycle 3p+1, G at 3p+2 and B at 3p+3.
- Read data for an address issued at cycle n is captured at the end of cycle n+1.
- The last B sample arrives in cycle 49153. The accumulators reflect it from cycle 49154.
- S_DRAIN occupies cycles 49153..49154.
- Found path:
  - S_DIVX occupies cycles 49155..49176 (22 cycles: 1 load + 21 iterations).
  - S_DIVY occupies cycles 49177..49198.
  - S_DONE is cycle 49199, with o_done high.
- Not-found path: S_DONE is cycle 49155.
- Outputs change only on the clock edge that ends S_DONE-1, so they are valid in the same cycle as o_done.
- o_rd_addr is 0 and o_rd_en is 0 outside S_SCAN.
- Count is 15 bits, so 16384 matches must not overflow.

## Structure
- Shared package holds:
  - the state enum
  - IMG_W, IMG_H, PLANE_OFS
  - accumulator widths (count 15, sum 21, coordinate 7)
- One sub-module, serial_divider_u21: restoring divider, 21-bit dividend by 15-bit divisor.
  - start/done handshake.
  - Fixed 22-cycle latency.
  - Produces a 21-bit quotient. ia_color_centroid uses the low 7 bits, which is safe because the quotient is always <= 127.

## Test plan
- Read model returns all planes = 0, reference (0,0,0), tol 0 -> count 16384, cx = 63, cy = 63, box 0..127 on both axes, o_done at cycle 49199.
- A 10x10 block of colour (500,200,100) at x 20..29, y 40..49, background 0, reference (505,195,100), tol 5 -> count 100, cx 24, cy 44, box x 20..29, y 40..49.
- Same block with tol 4 -> count 0, found = 0, all coordinates 0, o_done at cycle 49155.
- 15 matching pixels with MIN_COUNT 16 -> found = 0, count 15; 16 matching pixels -> found = 1.
- i_start re-pulsed mid-scan -> ignored, address sequence undisturbed. Reset at cycle 20000 -> all outputs 0, o_rd_en 0; a fresh start then completes normally.
- Check the read protocol: the address sequence is 0, 16384, 32768, 1, 16385, ..., and extreme values 0 and 1023 with ref 1023 and tol 1023 all match.
